// File: rtl/game_pkg.sv
// Shared game-flow types for the Othello controllers: the turn state encoding
// and the player-index width helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    WAIT     = 3'd2,
    VALIDATE = 3'd3,
    PASS     = 3'd4,
    NEXT     = 3'd5,
    OVER     = 3'd6
  } game_state_e;

  localparam int TIMER_W = 30;

  function automatic int player_width(input int num_players);
    return (num_players > 2) ? $clog2(num_players) : 1;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Bundle between the keypad/button front end, the validator, the board-init
// controller and the turn controller. master = turn controller side.
interface turn_controller_if #(
  parameter int PW = 1,
  parameter int MW = 6
);
  logic          go;
  logic          init_done;
  logic          ack;
  logic          nack;
  logic          no_move;
  logic          game_end;
  logic          init_start;
  logic          new_move;
  logic [PW-1:0] player;
  logic [MW-1:0] move_count;
  logic [PW-1:0] pass_count;
  logic          timed_out;
  logic          game_over;

  modport master (
    input  go, init_done, ack, nack, no_move, game_end,
    output init_start, new_move, player, move_count, pass_count, timed_out, game_over
  );

  modport slave (
    output go, init_done, ack, nack, no_move, game_end,
    input  init_start, new_move, player, move_count, pass_count, timed_out, game_over
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn cycle counter: runs while `run` is high, clears otherwise, and
// flags `expire` on the last allowed cycle.
module turn_timer #(
  parameter logic [29:0] TIMEOUT = 30'd500_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expire
);

  logic [29:0] count_q;
  logic [29:0] count_d;

  assign expire = run && (count_q == TIMEOUT - 30'd1);

  always_comb begin
    count_d = run ? count_q + 30'd1 : 30'd0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= 30'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Othello game-flow controller: board init, N-player turn rotation, passes and
// game-over detection. Define TURN_TIMER_EN to build the per-turn timeout.
module turn_controller
  import game_pkg::*;
#(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          MAX_MOVES    = 60,
  parameter logic [29:0] TURN_TIMEOUT = 30'd500_000_000,
  parameter int          PW           = player_width(NUM_PLAYERS),
  parameter int          MW           = $clog2(MAX_MOVES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  turn_controller_if.master bus
);

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [MW-1:0] MOVES_FULL  = MW'(MAX_MOVES);
  localparam logic [PW:0]   PASS_LIMIT  = (PW + 1)'(NUM_PLAYERS);

  game_state_e   state_q, state_d;
  logic          go_q;
  logic [PW-1:0] player_q, player_d;
  logic [MW-1:0] move_q, move_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          init_start_q, new_move_q, timed_out_q, game_over_q;
  logic          go_rise;
  logic          timer_expire;
  logic          timeout_take;
  logic [PW:0]   pass_inc;

  assign go_rise  = bus.go & ~go_q;
  assign pass_inc = {1'b0, pass_q} + (PW + 1)'(1);

`ifdef TURN_TIMER_EN
  logic timer_run;
  assign timer_run = (state_q == WAIT);

  turn_timer #(
    .TIMEOUT (TURN_TIMEOUT)
  ) u_turn_timer (
    .clock  (clock),
    .reset  (reset),
    .run    (timer_run),
    .expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    move_d       = move_q;
    pass_d       = pass_q;
    timeout_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_rise) begin
          state_d  = INIT;
          player_d = '0;
          move_d   = '0;
          pass_d   = '0;
        end
      end
      INIT: begin
        if (bus.init_done) state_d = WAIT;
      end
      WAIT: begin
        if (bus.game_end) begin
          state_d = OVER;
        end else if (bus.no_move) begin
          state_d = PASS;
        end else if (timer_expire) begin
          state_d      = PASS;
          timeout_take = 1'b1;
        end else if (go_rise) begin
          state_d = VALIDATE;
        end
      end
      VALIDATE: begin
        if (bus.game_end) begin
          state_d = OVER;
        end else if (bus.ack) begin
          state_d = NEXT;
          pass_d  = '0;
          if (move_q != MOVES_FULL) move_d = move_q + MW'(1);
        end else if (bus.nack) begin
          state_d = WAIT;
        end
      end
      PASS: begin
        // A full round of passes ends the game; game_over records that final
        // pass, so pass_count keeps the last value that fits in PW bits.
        if (bus.game_end || pass_inc == PASS_LIMIT) begin
          state_d = OVER;
        end else begin
          state_d = NEXT;
          pass_d  = pass_inc[PW-1:0];
        end
      end
      NEXT: begin
        if (bus.game_end) begin
          state_d = OVER;
        end else begin
          player_d = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
          state_d  = (move_q == MOVES_FULL) ? OVER : WAIT;
        end
      end
      OVER: begin
        if (go_rise) begin
          state_d  = INIT;
          player_d = '0;
          move_d   = '0;
          pass_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      go_q         <= 1'b1;
      player_q     <= '0;
      move_q       <= '0;
      pass_q       <= '0;
      init_start_q <= 1'b0;
      new_move_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      go_q         <= bus.go;
      player_q     <= player_d;
      move_q       <= move_d;
      pass_q       <= pass_d;
      init_start_q <= (state_d == INIT);
      new_move_q   <= (state_d == VALIDATE);
      timed_out_q  <= timeout_take;
      game_over_q  <= (state_d == OVER);
    end
  end

  assign bus.init_start = init_start_q;
  assign bus.new_move   = new_move_q;
  assign bus.player     = player_q;
  assign bus.move_count = move_q;
  assign bus.pass_count = pass_q;
  assign bus.timed_out  = timed_out_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed self-checking bench for turn_controller (2 players, 60 moves,
// 16-cycle timeout); the timeout section adapts to TURN_TIMER_EN.
module tb_turn_controller;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  turn_controller_if #(.PW(1), .MW(6)) bus ();

  turn_controller #(
    .NUM_PLAYERS  (2),
    .MAX_MOVES    (60),
    .TURN_TIMEOUT (30'd16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       go, init_done, ack, nack, no_move, game_end;
    logic       e_init, e_new, e_player;
    logic [5:0] e_moves;
    logic       e_pass, e_over;
  } vec_t;

  vec_t vecs [28];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".init_start"}, 32'(bus.init_start), 0);
    chk({tag, ".new_move"},   32'(bus.new_move), 0);
    chk({tag, ".player"},     32'(bus.player), 0);
    chk({tag, ".move_count"}, 32'(bus.move_count), 0);
    chk({tag, ".pass_count"}, 32'(bus.pass_count), 0);
    chk({tag, ".timed_out"},  32'(bus.timed_out), 0);
    chk({tag, ".game_over"},  32'(bus.game_over), 0);
  endtask

  task automatic drive(input logic g, input logic id, input logic a, input logic n,
                       input logic nm, input logic ge);
    bus.go = g; bus.init_done = id; bus.ack = a; bus.nack = n;
    bus.no_move = nm; bus.game_end = ge;
  endtask

  initial begin
    int init_cnt;
    int hit;
    int pulses;
    errors = 0;
    checks = 0;

    //           go id ak nk nm ge | init new pl moves pass over
    vecs[0]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 6'd0, 0, 0};  // IDLE
    vecs[1]  = '{1, 0, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, 0};  // INIT
    vecs[2]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 6'd0, 0, 0};  // WAIT
    vecs[4]  = '{1, 0, 0, 0, 0, 0,   0, 1, 0, 6'd0, 0, 0};  // VALIDATE
    vecs[5]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 6'd0, 0, 0};  // nack -> WAIT
    vecs[6]  = '{1, 0, 0, 0, 0, 0,   0, 1, 0, 6'd0, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 6'd1, 0, 0};  // ack -> NEXT
    vecs[8]  = '{0, 0, 1, 0, 0, 0,   0, 0, 1, 6'd1, 0, 0};  // held ack ignored
    vecs[9]  = '{1, 0, 0, 0, 0, 0,   0, 1, 1, 6'd1, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 0, 0,   0, 0, 1, 6'd2, 0, 0};  // ack+nack = accept
    vecs[11] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 6'd2, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 0,   0, 0, 0, 6'd2, 0, 0};  // PASS
    vecs[13] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 6'd2, 1, 0};  // NEXT
    vecs[14] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 6'd2, 1, 0};  // WAIT, player 1
    vecs[15] = '{1, 0, 0, 0, 0, 0,   0, 1, 1, 6'd2, 1, 0};
    vecs[16] = '{0, 0, 1, 0, 0, 0,   0, 0, 1, 6'd3, 0, 0};  // ack clears passes
    vecs[17] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 6'd3, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 1, 0,   0, 0, 0, 6'd3, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 6'd3, 1, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 6'd3, 1, 0};
    vecs[21] = '{0, 0, 0, 0, 1, 0,   0, 0, 1, 6'd3, 1, 0};  // second pass
    vecs[22] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 6'd3, 1, 1};  // OVER
    vecs[23] = '{1, 0, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, 0};  // rematch
    vecs[24] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 6'd0, 0, 0};
    vecs[25] = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 6'd0, 0, 1};  // game_end
    vecs[26] = '{1, 0, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, 0};
    vecs[27] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 6'd0, 0, 0};

    // Reset state
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_reset_values("reset");
    reset = 1'b1;
    tick();

    // Normal turn: init_start spans 6 cycles, then one accepted move
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    init_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.init_start) init_cnt++;
      if (i == 5) bus.init_done = 1'b1;
      tick();
    end
    bus.init_done = 1'b0;
    chk("init_cycles", 32'(init_cnt), 6);
    chk("init_start_low", 32'(bus.init_start), 0);
    bus.go = 1'b1;
    tick();
    chk("new_move_high", 32'(bus.new_move), 1);
    bus.go = 1'b0; bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    chk("turn.player", 32'(bus.player), 1);
    chk("turn.moves", 32'(bus.move_count), 1);
    $display("turn: player=%0d moves=%0d", bus.player, bus.move_count);

    // Reset asserted while in VALIDATE
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("pre_reset.new_move", 32'(bus.new_move), 1);
    reset = 1'b0;
    tick();
    chk_reset_values("mid_reset");
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].go, vecs[i].init_done, vecs[i].ack, vecs[i].nack,
            vecs[i].no_move, vecs[i].game_end);
      tick();
      $display("vec %0d: init=%0d new=%0d pl=%0d mv=%0d pc=%0d over=%0d", i,
               bus.init_start, bus.new_move, bus.player, bus.move_count,
               bus.pass_count, bus.game_over);
      chk($sformatf("vec%0d.init_start", i), 32'(bus.init_start), 32'(vecs[i].e_init));
      chk($sformatf("vec%0d.new_move", i),   32'(bus.new_move),   32'(vecs[i].e_new));
      chk($sformatf("vec%0d.player", i),     32'(bus.player),     32'(vecs[i].e_player));
      chk($sformatf("vec%0d.move_count", i), 32'(bus.move_count), 32'(vecs[i].e_moves));
      chk($sformatf("vec%0d.pass_count", i), 32'(bus.pass_count), 32'(vecs[i].e_pass));
      chk($sformatf("vec%0d.game_over", i),  32'(bus.game_over),  32'(vecs[i].e_over));
      chk($sformatf("vec%0d.timed_out", i),  32'(bus.timed_out),  0);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Full board: 60 accepted moves end the game
    for (int m = 1; m <= 60; m++) begin
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0; bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      tick();
      if (m == 59) begin
        chk("board59.game_over", 32'(bus.game_over), 0);
        chk("board59.moves", 32'(bus.move_count), 59);
      end
    end
    $display("board: moves=%0d over=%0d", bus.move_count, bus.game_over);
    chk("board.game_over", 32'(bus.game_over), 1);
    chk("board.moves", 32'(bus.move_count), 60);
    tick();
    chk("board.hold", 32'(bus.move_count), 60);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("rematch.init_start", 32'(bus.init_start), 1);
    chk("rematch.moves", 32'(bus.move_count), 0);
    chk("rematch.player", 32'(bus.player), 0);
    chk("rematch.game_over", 32'(bus.game_over), 0);
    bus.init_done = 1'b1;
    tick();
    bus.init_done = 1'b0;

    // Turn timeout
`ifdef TURN_TIMER_EN
    hit = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.timed_out) begin
        hit = k;
        break;
      end
    end
    $display("timeout: pulse after %0d cycles", hit);
    chk("timeout.cycles", 32'(hit), 16);
    tick();
    chk("timeout.single_pulse", 32'(bus.timed_out), 0);
    tick();
    chk("timeout.player", 32'(bus.player), 1);
    chk("timeout.pass_count", 32'(bus.pass_count), 1);
    pulses = 0;
`else
    hit = 0;
    pulses = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (bus.timed_out) pulses++;
    end
    $display("no timer: %0d pulses in 1000 cycles", pulses);
    chk("notimer.pulses", 32'(pulses), 0);
    chk("notimer.player", 32'(bus.player), 0);
    chk("notimer.new_move", 32'(bus.new_move), 0);
    chk("notimer.game_over", 32'(bus.game_over), 0);
`endif

    // go held high through reset release must not start a game
    reset = 1'b0;
    bus.go = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("held_go.init_start", 32'(bus.init_start), 0);
    chk("held_go.new_move", 32'(bus.new_move), 0);
    chk("held_go.game_over", 32'(bus.game_over), 0);
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("fresh_go.init_start", 32'(bus.init_start), 1);
    $display("held go: init_start after fresh edge=%0d", bus.init_start);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
